// File: rtl/div_unit_if.sv
// Request/response handshake bundle for div_unit.
// The master side issues divide requests; the slave side is the divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             busy;

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, flush, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, busy
  );

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, flush, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, busy
  );
endinterface

// File: rtl/div_unit.sv
// Fixed-latency restoring radix-2 divider, signed or unsigned, one quotient bit per cycle.
// Sign handling is done on magnitudes; fix-up is applied combinationally on the held result.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          resetn,
  div_unit_if.slave    bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   trial;
  logic             accept;
  logic [WIDTH-1:0] q_fix, r_fix;

  // abs(MIN) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
  assign dvd_abs = (bus.in_signed && bus.in_dividend[WIDTH-1]) ? -bus.in_dividend
                                                                : bus.in_dividend;
  assign dvs_abs = (bus.in_signed && bus.in_divisor[WIDTH-1]) ? -bus.in_divisor
                                                               : bus.in_divisor;
  assign accept  = bus.in_valid && (state_q == StIdle) && !bus.flush;

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StCalc;
          cnt_d     = CntW'(WIDTH);
          rem_d     = '0;
          quo_d     = dvd_abs;
          dvs_d     = dvs_abs;
          dvd_d     = bus.in_dividend;
          neg_quo_d = bus.in_signed && (bus.in_dividend[WIDTH-1] ^ bus.in_divisor[WIDTH-1]);
          neg_rem_d = bus.in_signed && bus.in_dividend[WIDTH-1];
          zero_d    = (bus.in_divisor == '0);
        end
      end
      StCalc: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
    end
  end

  always_comb begin
    q_fix = neg_quo_q ? -quo_q : quo_q;
    r_fix = neg_rem_q ? -rem_q : rem_q;
    if (zero_q) begin
      q_fix = '1;
      r_fix = dvd_q;
    end
  end

  assign bus.in_ready      = (state_q == StIdle);
  assign bus.busy          = (state_q != StIdle);
  assign bus.out_valid     = (state_q == StDone);
  assign bus.out_quotient  = (state_q == StDone) ? q_fix : '0;
  assign bus.out_remainder = (state_q == StDone) ? r_fix : '0;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit (WIDTH=32): directed vector table, handshake/flush/reset sequences,
// and random operands checked against an arithmetic reference model.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic clk;
  logic resetn;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sa == -64'sd2147483648 && sb == -64'sd1) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
    end
  endfunction

  task automatic start(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_signed   = s;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.in_dividend = $urandom;
    bus.in_divisor  = $urandom;
    bus.in_signed   = $urandom_range(0, 1);
  endtask

  // Returns the number of edges after acceptance until out_valid; busy_ok tracks busy in CALC
  task automatic wait_done(output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && n < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input string name, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int   n;
    logic bok;
    start(s, a, b);
    wait_done(n, bok);
    check({name, " latency"}, 64'(n), 64'd32);
    check({name, " busy"}, 64'(bok), 64'd1);
    check({name, " quotient"}, 64'(bus.out_quotient), 64'(eq));
    check({name, " remainder"}, 64'(bus.out_remainder), 64'(er));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb, eq, er, hq, hr;
    logic        rs, stable, never;
    int          n;
    logic        bok;

    total = 0;
    bad   = 0;
    bus.in_valid    = 1'b0;
    bus.in_signed   = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;

    vecs[0] = '{"u 100/7",       1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
    vecs[1] = '{"s -7/2",        1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2] = '{"s 7/-2",        1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vecs[3] = '{"u big/2",       1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1};
    vecs[4] = '{"s MIN/-1",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[5] = '{"s -5/0",        1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[6] = '{"u x/0",         1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678};
    vecs[7] = '{"s -8/-3",       1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFE};

    resetn = 1'b0;
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset out_quotient", 64'(bus.out_quotient), 64'd0);
    check("reset out_remainder", 64'(bus.out_remainder), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      check({vecs[i].name, " idle after handshake"}, 64'(bus.in_ready), 64'd1);
    end

    // Back-pressure: result and handshake state must hold while out_ready is low
    start(1'b0, 32'd100, 32'd7);
    wait_done(n, bok);
    check("stall latency", 64'(n), 64'd32);
    hq = bus.out_quotient;
    hr = bus.out_remainder;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.out_quotient !== hq || bus.out_remainder !== hr || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1) stable = 1'b0;
    end
    check("stall stable", 64'(stable), 64'd1);
    check("stall quotient", 64'(hq), 64'd14);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("release in_ready", 64'(bus.in_ready), 64'd1);
    check("release out_valid", 64'(bus.out_valid), 64'd0);
    check("release quotient zero", 64'(bus.out_quotient), 64'd0);

    // Flush at CALC step 10
    start(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush calc in_ready", 64'(bus.in_ready), 64'd1);
    check("flush calc busy", 64'(bus.busy), 64'd0);
    never = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) never = 1'b0;
    end
    check("flush calc no result", 64'(never), 64'd1);

    // Flush beats a same-cycle request in IDLE
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_signed   = 1'b0;
    bus.in_dividend = 32'd5;
    bus.in_divisor  = 32'd1;
    bus.flush       = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush idle not accepted", 64'(bus.in_ready), 64'd1);
    never = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) never = 1'b0;
    end
    check("flush idle no result", 64'(never), 64'd1);
    do_op("after flush 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Asynchronous reset mid-CALC
    start(1'b1, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async rst in_ready", 64'(bus.in_ready), 64'd1);
    check("async rst busy", 64'(bus.busy), 64'd0);
    check("async rst outputs", {bus.out_quotient, bus.out_remainder}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    do_op("after reset 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Random operands against the reference model
    for (int k = 0; k < 60; k++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = -($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if (k % 10 == 3) ra = 32'h8000_0000;
      model(rs, ra, rb, eq, er);
      do_op($sformatf("rand%0d %0h/%0h s=%0d", k, ra, rb, rs), rs, ra, rb, eq, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32; operand/result width in bits; legal values are even and >= 4.
REQ-002 SHALL have clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL have resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  request present.
REQ-005 SHALL have in_ready  output  1  unit can accept a request.
REQ-006 SHALL have in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have in_dividend  input  WIDTH  dividend (rj).
REQ-008 SHALL have in_divisor  input  WIDTH  divisor (rk).
REQ-009 SHALL have flush  input  1  cancel any in-flight operation (pipeline flush/exception).
REQ-010 SHALL have out_valid  output  1  result present.
REQ-011 SHALL have out_ready  input  1  consumer takes the result.
REQ-012 SHALL have out_quotient  output  WIDTH  quotient.
REQ-013 SHALL have out_remainder  output  WIDTH  remainder.
REQ-014 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 SHALL drive in_ready = (state==IDLE); a request is accepted at an edge where in_valid & in_ready & ~flush.
REQ-017 SHALL latch operands and in_signed at acceptance, then go to CALC with the iteration counter loaded to WIDTH; later input changes SHALL have no effect.
REQ-018 SHALL, when in_signed, divide |dividend| by |divisor| as unsigned WIDTH-bit values; abs(MIN) SHALL equal 2^(WIDTH-1) unsigned.
REQ-019 SHALL perform one restoring radix-2 step per CALC cycle, producing 1 quotient bit per step, MSB first.
REQ-020 SHALL leave CALC for DONE at the edge completing step WIDTH, so out_valid is first high WIDTH cycles after the accepting edge; latency SHALL be fixed for all operand values.
REQ-021 SHALL apply signed fix-up: negate the quotient if the operand signs differ; the remainder takes the dividend's sign; results are truncated toward zero.
REQ-022 SHALL, for signed MIN / -1, return quotient = MIN and remainder = 0.
REQ-023 SHALL, for divisor = 0 (either mode), return quotient = all ones and remainder = the original dividend, bypassing sign fix-up.
REQ-024 SHALL hold out_valid, out_quotient and out_remainder stable in DONE until out_valid & out_ready, then return to IDLE; in_ready SHALL stay low in that same cycle (no same-cycle re-accept).
REQ-025 SHALL, on flush=1 at any edge, go to IDLE and clear out_valid; flush SHALL override a same-cycle acceptance and a same-cycle out handshake.
REQ-026 SHALL keep out_quotient and out_remainder at 0 whenever out_valid is 0.

Reset
REQ-027 SHALL, while resetn=0, immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, out_quotient=0 and out_remainder=0, regardless of clk.
REQ-028 SHALL, when resetn is asserted mid-CALC or in DONE, discard the operation; the first accepted request after reset SHALL complete correctly.

Verification (WIDTH=32)
REQ-029 Unsigned 100/7 -> q=14, r=2; out_valid first high 32 cycles after acceptance; busy high throughout.
REQ-030 Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1; unsigned 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
REQ-031 Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; signed 0xFFFFFFFB/0 -> q=0xFFFFFFFF, r=0xFFFFFFFB.
REQ-032 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge and in_ready=1.
REQ-033 flush pulsed at CALC step 10 -> IDLE next edge, out_valid never asserted; flush with in_valid in IDLE -> request not accepted; a following 9/3 -> q=3, r=0.
REQ-034 resetn low for 1 cycle mid-CALC -> outputs zero immediately, in_ready=1; a following 9/3 -> q=3, r=0.
